// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM generator's SPI front end.
package pwm_pkg;

   localparam int SPI_BYTE_W = 8;
   localparam int SPI_CNT_W  = 3;
   localparam int SPI_LOAD_W = 2;

   typedef logic [SPI_BYTE_W-1:0] spi_byte_t;
   typedef logic [SPI_CNT_W-1:0]  spi_cnt_t;
   typedef logic [SPI_LOAD_W-1:0] spi_load_t;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_t;

   // MSB-first shift: the oldest bit leaves at the top, the new bit enters at the bottom.
   function automatic spi_byte_t shift_in(input spi_byte_t sr, input logic bit_in);
      return {sr[SPI_BYTE_W-2:0], bit_in};
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchronizer for one asynchronous pin, with a configurable reset value.
module sync_ff #(
   parameter int   DEPTH   = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [DEPTH-1:0] stage_q;

   // Shift the pin through the chain; the last stage is the synchronized value.
   always_ff @(posedge clk) begin
      // NOTE: registers use <= so every stage samples the previous stage's old value.
      if (rst) stage_q <= {DEPTH{RST_VAL}};
      else     stage_q <= {stage_q[DEPTH-2:0], d_i};
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/spi_bridge.sv
// SPI mode-0 slave front end: oversampled pins, byte deserializer with a one-cycle
// strobe toward instr_dcd, and a MISO serializer reloaded from instr_dcd's data_out.
module spi_bridge
   import pwm_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int LOAD_DLY    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sclk,
   input  logic                  cs_n,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  byte_sync,
   output logic [SPI_BYTE_W-1:0] data_in,
   input  logic [SPI_BYTE_W-1:0] data_out
);

   localparam spi_load_t LOAD_INIT = spi_load_t'(LOAD_DLY);
   localparam spi_cnt_t  LAST_BIT  = spi_cnt_t'(SPI_BYTE_W - 1);

   logic sclk_s, cs_n_s, mosi_s;
   logic sclk_d1_q, cs_n_d1_q;
   logic sclk_rise, sclk_fall, cs_fall, cs_rise;

   spi_state_t state_q, state_d;
   spi_cnt_t   bit_cnt_q, bit_cnt_d;
   spi_byte_t  rx_sr_q, rx_sr_d;
   spi_byte_t  tx_sr_q, tx_sr_d;
   spi_byte_t  data_in_q, data_in_d;
   logic       byte_sync_q, byte_sync_d;
   logic       miso_q, miso_d;
   spi_load_t  load_cnt_q, load_cnt_d;

   sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk (clk),
      .rst (rst),
      .d_i (sclk),
      .q_o (sclk_s)
   );

   sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
      .clk (clk),
      .rst (rst),
      .d_i (cs_n),
      .q_o (cs_n_s)
   );

   sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk (clk),
      .rst (rst),
      .d_i (mosi),
      .q_o (mosi_s)
   );

   // Edges are the last sync stage against one extra registered copy.
   assign sclk_rise =  sclk_s & ~sclk_d1_q;
   assign sclk_fall = ~sclk_s &  sclk_d1_q;
   assign cs_fall   = ~cs_n_s &  cs_n_d1_q;
   assign cs_rise   =  cs_n_s & ~cs_n_d1_q;

   // Next-state logic: frame control, RX deserializer, TX serializer and reload timer.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_sr_d     = rx_sr_q;
      tx_sr_d     = tx_sr_q;
      data_in_d   = data_in_q;
      byte_sync_d = 1'b0;
      load_cnt_d  = load_cnt_q;

      unique case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d    = ACTIVE;
               bit_cnt_d  = '0;
               tx_sr_d    = data_out;
               load_cnt_d = '0;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               // Abort: a partial byte is dropped, even if an sclk rise lands in this cycle.
               state_d    = IDLE;
               bit_cnt_d  = '0;
               load_cnt_d = '0;
            end else begin
               if (load_cnt_q != '0) load_cnt_d = load_cnt_q - spi_load_t'(1);

               if (sclk_rise) begin
                  rx_sr_d   = shift_in(rx_sr_q, mosi_s);
                  bit_cnt_d = bit_cnt_q + spi_cnt_t'(1);
                  if (bit_cnt_q == LAST_BIT) begin
                     data_in_d   = shift_in(rx_sr_q, mosi_s);
                     byte_sync_d = 1'b1;
                     load_cnt_d  = LOAD_INIT;
                  end
               end

               // The reload beats a same-cycle fall; a fall on the byte boundary never shifts.
               if (load_cnt_q == spi_load_t'(1)) begin
                  tx_sr_d = data_out;
               end else if (sclk_fall && (bit_cnt_q != '0)) begin
                  tx_sr_d = {tx_sr_q[SPI_BYTE_W-2:0], 1'b0};
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // MISO is registered from the next TX MSB so it moves one cycle after the synced fall.
      miso_d = (state_d == ACTIVE) ? tx_sr_d[SPI_BYTE_W-1] : 1'b0;
   end

   // State register with synchronous reset of every field.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_d1_q   <= 1'b0;
         cs_n_d1_q   <= 1'b1;
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         rx_sr_q     <= '0;
         tx_sr_q     <= '0;
         data_in_q   <= '0;
         byte_sync_q <= 1'b0;
         miso_q      <= 1'b0;
         load_cnt_q  <= '0;
      end else begin
         sclk_d1_q   <= sclk_s;
         cs_n_d1_q   <= cs_n_s;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_sr_q     <= rx_sr_d;
         tx_sr_q     <= tx_sr_d;
         data_in_q   <= data_in_d;
         byte_sync_q <= byte_sync_d;
         miso_q      <= miso_d;
         load_cnt_q  <= load_cnt_d;
      end
   end

   assign miso      = miso_q;
   assign byte_sync = byte_sync_q;
   assign data_in   = data_in_q;

endmodule
